// File: rtl/uart_pkg.sv
// uart_pkg: shared UART definitions (receiver FSM states, data width, parity encodings, parity helper).
package uart_pkg;
  localparam int DATA_W = 8;
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD = 1'b1;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_e;
  function automatic logic par_bit(input logic [DATA_W-1:0] d, input logic typ);
    return ^d ^ typ;
  endfunction
endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: per-bit oversampling counter and sample-point decision for uart_rx.
// Ports: clck, rst (sync, active-high); run_i keeps the counter running (low forces it to 0);
//   rxs_i synchronized line; samp_valid_o/samp_bit_o one-cycle sample decision; bit_end_o last cycle of a bit.
// Build option: UART_RX_MAJORITY_VOTE_EN takes a 2-of-3 vote over SP-1..SP+1, decided at SP+1.
module uart_rx_sampler #(
  parameter int OVERSAMPLE = 8
) (
  input  logic clck,
  input  logic rst,
  input  logic run_i,
  input  logic rxs_i,
  output logic samp_valid_o,
  output logic samp_bit_o,
  output logic bit_end_o
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] SP = CW'(OVERSAMPLE / 2);
  localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  assign bit_end_o = cnt_q == LAST;
  assign cnt_d = (!run_i || bit_end_o) ? '0 : cnt_q + 1'b1;
  always_ff @(posedge clck) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
`ifdef UART_RX_MAJORITY_VOTE_EN
  // win_q[1] holds the SP-1 sample, win_q[0] the SP sample; the third vote is the live line at SP+1.
  logic [1:0] win_q, win_d;
  assign win_d = (cnt_q == SP - 1'b1 || cnt_q == SP) ? {win_q[0], rxs_i} : win_q;
  assign samp_valid_o = cnt_q == SP + 1'b1;
  assign samp_bit_o = (win_q[1] & win_q[0]) | (win_q[1] & rxs_i) | (win_q[0] & rxs_i);
  always_ff @(posedge clck) begin
    if (rst) win_q <= 2'b11;
    else win_q <= win_d;
  end
`else
  assign samp_valid_o = cnt_q == SP;
  assign samp_bit_o = rxs_i;
`endif
endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver, start + 8 data bits LSB first + optional parity + 1 stop bit.
// Ports: clck oversampling clock; rst sync active-high; rx_in async serial line (idles high);
//   par_en/par_typ parity enable and type (latched at start of frame); p_data last good byte;
//   data_valid/par_err/stp_err one-cycle strobes at end of stop bit; busy high while not IDLE.
// Build option: UART_RX_MAJORITY_VOTE_EN enables majority-vote sampling in uart_rx_sampler.
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 8
) (
  input  logic                clck,
  input  logic                rst,
  input  logic                rx_in,
  input  logic                par_en,
  input  logic                par_typ,
  output logic [DATA_W-1:0]   p_data,
  output logic                data_valid,
  output logic                par_err,
  output logic                stp_err,
  output logic                busy
);
  logic sync_q, rxs_q;
  uart_state_e state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d, p_data_q, p_data_d;
  logic par_en_q, par_en_d, par_typ_q, par_typ_d, perr_q, perr_d, stop_q, stop_d;
  logic dv_q, dv_d, pe_q, pe_d, se_q, se_d;
  logic samp_valid, samp_bit, bit_end, stop_bit;
  uart_rx_sampler #(.OVERSAMPLE(OVERSAMPLE)) u_sampler (
    .clck(clck),
    .rst(rst),
    .run_i(state_d != IDLE),
    .rxs_i(rxs_q),
    .samp_valid_o(samp_valid),
    .samp_bit_o(samp_bit),
    .bit_end_o(bit_end)
  );
  always_comb begin
    state_d = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d = shift_q;
    p_data_d = p_data_q;
    par_en_d = par_en_q;
    par_typ_d = par_typ_q;
    perr_d = perr_q;
    stop_d = stop_q;
    dv_d = 1'b0;
    pe_d = 1'b0;
    se_d = 1'b0;
    // With a small OVERSAMPLE and voting, the stop decision can land on the bit's last cycle.
    stop_bit = samp_valid ? samp_bit : stop_q;
    case (state_q)
      IDLE: if (!rxs_q) begin
        state_d = START;
        par_en_d = par_en;
        par_typ_d = par_typ;
        perr_d = 1'b0;
        bit_cnt_d = 3'd0;
      end
      START: if (samp_valid && samp_bit) state_d = IDLE;
        else if (bit_end) state_d = DATA;
      DATA: begin
        if (samp_valid) shift_d[bit_cnt_q] = samp_bit;
        if (bit_end) begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = par_en_q ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (samp_valid) perr_d = samp_bit != par_bit(shift_q, par_typ_q);
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        if (samp_valid) stop_d = samp_bit;
        if (bit_end) begin
          state_d = IDLE;
          se_d = !stop_bit;
          pe_d = stop_bit && perr_q;
          dv_d = stop_bit && !perr_q;
          p_data_d = dv_d ? shift_q : p_data_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clck) begin
    if (rst) begin
      sync_q <= 1'b1;
      rxs_q <= 1'b1;
      state_q <= IDLE;
      bit_cnt_q <= 3'd0;
      shift_q <= '0;
      p_data_q <= '0;
      par_en_q <= 1'b0;
      par_typ_q <= PAR_EVEN;
      perr_q <= 1'b0;
      stop_q <= 1'b1;
      dv_q <= 1'b0;
      pe_q <= 1'b0;
      se_q <= 1'b0;
    end else begin
      sync_q <= rx_in;
      rxs_q <= sync_q;
      state_q <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q <= shift_d;
      p_data_q <= p_data_d;
      par_en_q <= par_en_d;
      par_typ_q <= par_typ_d;
      perr_q <= perr_d;
      stop_q <= stop_d;
      dv_q <= dv_d;
      pe_q <= pe_d;
      se_q <= se_d;
    end
  end
  assign p_data = p_data_q;
  assign data_valid = dv_q;
  assign par_err = pe_q;
  assign stp_err = se_q;
  assign busy = state_q != IDLE;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed, table-driven bench for uart_rx with OVERSAMPLE = 8.
module tb_uart_rx;
  localparam int OS = 8;
  logic clck = 1'b0, rst = 1'b1, rx_in = 1'b1, par_en = 1'b0, par_typ = 1'b0;
  logic [7:0] p_data;
  logic data_valid, par_err, stp_err, busy;
  int cyc = 0, checks = 0, errors = 0;
  typedef struct {int c; logic [2:0] k; logic [7:0] pd;} strobe_t;
  typedef struct {logic [7:0] d; logic pen, ptyp, pbit, sbit; logic [2:0] k; logic [7:0] pd;} vec_t;
  strobe_t q[$];
  vec_t v[6];
  uart_rx #(.OVERSAMPLE(OS)) dut (
    .clck(clck), .rst(rst), .rx_in(rx_in), .par_en(par_en), .par_typ(par_typ),
    .p_data(p_data), .data_valid(data_valid), .par_err(par_err), .stp_err(stp_err), .busy(busy)
  );
  always #5 clck = ~clck;
  always @(posedge clck) cyc <= cyc + 1;
  // Every strobe cycle becomes its own record, so a strobe held for two cycles shows up as an extra record.
  always @(negedge clck)
    if (data_valid || par_err || stp_err) q.push_back('{cyc, {data_valid, par_err, stp_err}, p_data});
  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end
  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask
  task automatic expect_strobe(input string name, input int c, input logic [2:0] k, input logic [7:0] pd);
    strobe_t s;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL %s: no strobe, required cycle %0d kind %b p_data %h", name, c, k, pd);
    end else begin
      s = q.pop_front();
      if (s.c != c || s.k !== k || s.pd !== pd) begin
        errors++;
        $display("FAIL %s: got cycle %0d kind %b p_data %h, required cycle %0d kind %b p_data %h",
                 name, s.c, s.k, s.pd, c, k, pd);
      end
    end
  endtask
  task automatic expect_none(input string name);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s: got %0d unexpected strobes, required 0", name, q.size());
      q.delete();
    end
  endtask
  task automatic drive_bit(input logic b, input int n);
    rx_in = b;
    repeat (n) @(negedge clck);
  endtask
  task automatic send(input logic [7:0] d, input logic pen, input logic pbit, input logic sbit, output int ts);
    ts = cyc;
    drive_bit(1'b0, OS);
    for (int i = 0; i < 8; i++) drive_bit(d[i], OS);
    if (pen) drive_bit(pbit, OS);
    drive_bit(sbit, OS);
  endtask
  initial begin
    int ts, t1, t2;
    logic [7:0] spike_exp;
    // {data, par_en, par_typ, parity bit on line, stop bit, {dv,pe,se}, p_data after}
    v[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 3'b100, 8'hA5};
    v[1] = '{8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 3'b100, 8'h3C};
    v[2] = '{8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 3'b010, 8'h3C};
    v[3] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 3'b100, 8'h00};
    v[4] = '{8'h01, 1'b1, 1'b1, 1'b0, 1'b1, 3'b100, 8'h01};
    v[5] = '{8'h81, 1'b1, 1'b1, 1'b1, 1'b1, 3'b100, 8'h81};
    repeat (3) @(negedge clck);
    rst = 1'b0;
    @(negedge clck);
    chk("reset p_data", p_data, 8'h00);
    chk("reset data_valid", {7'd0, data_valid}, 8'h00);
    chk("reset par_err", {7'd0, par_err}, 8'h00);
    chk("reset stp_err", {7'd0, stp_err}, 8'h00);
    chk("reset busy", {7'd0, busy}, 8'h00);
    for (int i = 0; i < 6; i++) begin
      par_en = v[i].pen;
      par_typ = v[i].ptyp;
      send(v[i].d, v[i].pen, v[i].pbit, v[i].sbit, ts);
      rx_in = 1'b1;
      repeat (4) @(negedge clck);
      expect_strobe($sformatf("vec%0d", i), ts + 2 + (v[i].pen ? 11 : 10) * OS, v[i].k, v[i].pd);
    end
    // Stop bit low and parity wrong, then a clean frame with no idle gap.
    par_en = 1'b1;
    par_typ = 1'b0;
    send(8'h3C, 1'b1, 1'b1, 1'b0, t1);
    par_en = 1'b0;
    send(8'h5A, 1'b0, 1'b0, 1'b1, t2);
    rx_in = 1'b1;
    repeat (4) @(negedge clck);
    expect_strobe("stop error", t1 + 2 + 11 * OS, 3'b001, 8'h81);
    expect_strobe("back-to-back", t2 + 2 + 10 * OS, 3'b100, 8'h5A);
    // Two-cycle low glitch on the idle line.
    ts = cyc;
    drive_bit(1'b0, 2);
    drive_bit(1'b1, 1);
    chk("glitch busy high", {7'd0, busy}, 8'h01);
    repeat (8) @(negedge clck);
    chk("glitch busy low", {7'd0, busy}, 8'h00);
    repeat (4) @(negedge clck);
    expect_none("glitch strobe");
    // One-cycle high spike at the sample point of data bit 3 of 8'h00.
`ifdef UART_RX_MAJORITY_VOTE_EN
    spike_exp = 8'h00;
`else
    spike_exp = 8'h08;
`endif
    ts = cyc;
    drive_bit(1'b0, OS + 3 * OS + 4);
    drive_bit(1'b1, 1);
    drive_bit(1'b0, 3 + 4 * OS);
    drive_bit(1'b1, OS);
    repeat (4) @(negedge clck);
    expect_strobe("spike", ts + 2 + 10 * OS, 3'b100, spike_exp);
    // Reset for one cycle in the middle of DATA.
    drive_bit(1'b0, OS);
    drive_bit(1'b1, 2 * OS);
    rst = 1'b1;
    @(negedge clck);
    rst = 1'b0;
    chk("mid rst p_data", p_data, 8'h00);
    chk("mid rst data_valid", {7'd0, data_valid}, 8'h00);
    chk("mid rst par_err", {7'd0, par_err}, 8'h00);
    chk("mid rst stp_err", {7'd0, stp_err}, 8'h00);
    chk("mid rst busy", {7'd0, busy}, 8'h00);
    repeat (8 * OS) @(negedge clck);
    expect_none("mid rst strobe");
    send(8'hFF, 1'b0, 1'b0, 1'b1, ts);
    rx_in = 1'b1;
    repeat (4) @(negedge clck);
    expect_strobe("after rst", ts + 2 + 10 * OS, 3'b100, 8'hFF);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
# uart_rx

Oversampling UART receiver; the downstream peer of the codebase's UART transmitter. Consumes the serial line driven by the transmitter's TX_OUT: start bit, 8 data bits LSB first, optional parity bit, one stop bit. Delivers the byte on p_data with a one-cycle data_valid strobe and flags parity and stop-bit errors. Runs on the oversampling clock, which is OVERSAMPLE × baud.

## Interface
- OVERSAMPLE, 8: clck cycles per bit. Even, ≥ 4.
- clck  in  1  oversampling clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- rx_in  in  1  serial line; asynchronous; idles high
- par_en  in  1  1 = parity bit present in frame
- par_typ  in  1  0 = even parity, 1 = odd parity
- p_data  out  8  last good received byte; held until the next good frame
- data_valid  out  1  one-cycle strobe: p_data updated
- par_err  out  1  one-cycle strobe: parity mismatch
- stp_err  out  1  one-cycle strobe: stop bit sampled 0
- busy  out  1  high while the receiver is not in IDLE

## Operation
- rx_in passes through a 2-flop synchronizer (reset value 1); all logic uses the synchronized line rxs.
- States: IDLE, START, DATA, PARITY, STOP.
- edge_cnt counts 0..OVERSAMPLE-1 within each bit. bit_cnt counts 0..7 in DATA.
- Sample point SP = OVERSAMPLE/2. The sampled bit value is captured at edge_cnt == SP.
- IDLE: when rxs == 0, go to START with edge_cnt = 0 in that cycle. Latch par_en and par_typ at this point; changes later in the frame are ignored.
- START: if the sample is 1, treat it as a glitch. Return to IDLE at SP+1 with no strobe. Otherwise, at edge_cnt == OVERSAMPLE-1, go to DATA.
- DATA: shift the sample into bit position bit_cnt (LSB first). After bit 7 ends, go to PARITY if par_en is latched as 1, else go to STOP.
- PARITY: the expected bit is the XOR of the 8 data bits, XORed with par_typ. Record a mismatch and go to STOP.
- STOP: at the end of the bit (edge_cnt == OVERSAMPLE-1), go to IDLE. Exactly one of the following is registered at that edge:
  - stp_err, if the stop sample is 0;
  - else par_err, if a parity mismatch was recorded;
  - else data_valid, with p_data loaded.
- stp_err takes priority over par_err. An erroneous frame never updates p_data.
- A start bit is accepted in the cycle immediately after returning to IDLE, so back-to-back frames need no idle gap.
- rxs staying low through the stop bit (break) gives stp_err. The receiver then re-enters START from IDLE, because the line is still low.

## Timing
- Reset values: p_data = 8'h00, data_valid = 0, par_err = 0, stp_err = 0, busy = 0. State is IDLE and all counters are 0.
- rst asserted mid-frame aborts the frame in the next cycle. No strobe is issued.
- t0 is the cycle in which IDLE sees rxs == 0. t0 is 2 cycles after rx_in falls, because of the synchronizer.
- N = 10 bits per frame, or 11 with parity.
- Strobes are visible in cycle t0 + N·OVERSAMPLE, and last exactly one cycle.
- busy is high from t0+1 through t0 + N·OVERSAMPLE - 1.

## Configuration
- UART_RX_MAJORITY_VOTE_EN defined:
  - Each bit's sample is the 2-of-3 majority of rxs at edge_cnt SP-1, SP and SP+1.
  - The decision is taken at SP+1, so a glitch on START returns to IDLE at SP+2.
- Undefined: a single sample at SP. All other timing is unchanged.

## Structure
- Shared package uart_pkg holds:
  - the state enum;
  - the DATA_W = 8 constant;
  - the parity-type encodings PAR_EVEN = 0 and PAR_ODD = 1. The transmitter uses the same encodings.
- One sub-module, uart_rx_sampler, holds:
  - edge_cnt;
  - the SP window;
  - the majority vote.
- It outputs samp_valid and samp_bit to the FSM and shifter in uart_rx.

## Test plan
- Frame 8'hA5, no parity, OVERSAMPLE = 8: data_valid in cycle t0+80 and p_data = 8'hA5; par_err = 0, stp_err = 0.
- Frame 8'h3C, par_en = 1, even parity, parity bit 0: data_valid in cycle t0+88. Repeat with the parity bit forced to 1: par_err only, and p_data keeps its previous value.
- Odd parity, frame 8'h01, parity bit 0: data_valid, with p_data = 8'h01.
- Stop bit forced to 0, with parity also wrong: stp_err only, with no par_err and no data_valid. Then a valid frame 8'h5A sent with no gap: data_valid and p_data = 8'h5A.
- 2-cycle low glitch on the idle line: busy pulses, then returns low, with no strobe.
  - With UART_RX_MAJORITY_VOTE_EN, a 1-cycle high spike at SP inside data bit 3 of 8'h00 gives p_data = 8'h00.
  - Without the macro, the same stimulus gives 8'h08.
- rst asserted for 1 cycle mid-DATA: every output reads its reset value, and the next clean frame 8'hFF is received correctly.
